// File: rtl/ifft_output_restore.sv
// ifft_output_restore: undo the IFFT real/imag swap and apply rounded 1/N scaling on a two-stage valid/ready stream
module ifft_output_restore #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN = 64,
  parameter int SCALE_SHIFT = 6
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] A32,
  input  logic                    Swap,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [2*DATA_WIDTH-1:0] R32,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic                    Out_Last
);
  localparam int W = 2 * DATA_WIDTH;
  localparam int CW = $clog2(FRAME_LEN);
  localparam int RND = (1 << SCALE_SHIFT) >> 1;
  logic [CW-1:0] cnt;
  logic          swap_q, s1_v, s1_last, s2_adv, acc, first, sw;
  logic [W-1:0]  s1_d;
  // One guard bit keeps the rounding add from overflowing.
  function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH:0] t;
    t = $signed({x[DATA_WIDTH-1], x}) + $signed((DATA_WIDTH+1)'(RND));
    t = t >>> SCALE_SHIFT;
    return t[DATA_WIDTH-1:0];
  endfunction
  always_comb begin
    s2_adv   = !Out_Valid | Out_Ready;
    In_Ready = !RST & (!s1_v | s2_adv);
    acc      = In_Valid & In_Ready;
    first    = cnt == '0;
    sw       = first ? Swap : swap_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      swap_q  <= 1'b0;
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_d    <= '0;
    end else begin
      if (In_Ready) s1_v <= In_Valid;
      if (acc) begin
        cnt     <= cnt + 1'b1;
        s1_d    <= sw ? {A32[DATA_WIDTH-1:0], A32[W-1:DATA_WIDTH]} : A32;
        s1_last <= cnt == CW'(FRAME_LEN - 1);
        if (first) swap_q <= Swap;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      Out_Valid <= 1'b0;
      Out_Last  <= 1'b0;
      R32       <= '0;
    end else if (s2_adv) begin
      Out_Valid <= s1_v;
      Out_Last  <= s1_v & s1_last;
      if (s1_v) R32 <= {scale(s1_d[W-1:DATA_WIDTH]), scale(s1_d[DATA_WIDTH-1:0])};
    end
  end
endmodule

// File: tb/tb_ifft_output_restore.sv
// tb_ifft_output_restore: random and directed stimulus against a queue-based model, one DUT scaled and one unscaled
module tb_ifft_output_restore;
  logic        CLK = 0, RST = 0, Swap = 0, In_Valid = 0, Out_Ready = 0;
  logic [31:0] A32 = 0;
  logic        In_Ready, Out_Valid, Out_Last, In_Ready_z, Out_Valid_z, Out_Last_z;
  logic [31:0] R32, R32_z;
  int          checks = 0, errors = 0;
  logic [32:0] q0[$], q1[$];
  int          lasts[$];
  int          m_idx = 0, out_cnt = 0;
  logic        m_sw = 0;

  ifft_output_restore dut (
    .CLK(CLK), .RST(RST), .A32(A32), .Swap(Swap), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .R32(R32), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Last(Out_Last)
  );
  ifft_output_restore #(.SCALE_SHIFT(0)) dut_z (
    .CLK(CLK), .RST(RST), .A32(A32), .Swap(Swap), .In_Valid(In_Valid), .In_Ready(In_Ready_z),
    .R32(R32_z), .Out_Valid(Out_Valid_z), .Out_Ready(Out_Ready), .Out_Last(Out_Last_z)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] mscale(input logic [15:0] x, input int s);
    int v, d;
    if (s == 0) return x;
    d = 1 << s;
    v = int'($signed(x)) + d / 2;
    return 16'(v >= 0 ? v / d : -((-v + d - 1) / d));
  endfunction

  // Scoreboard: model every accept, compare every output handshake of both DUTs.
  initial begin
    logic        sw, lst;
    logic [15:0] re, im;
    logic [32:0] e;
    forever begin
      @(posedge CLK);
      if (RST) begin
        q0.delete(); q1.delete(); lasts.delete();
        m_idx = 0; out_cnt = 0;
      end else begin
        if (In_Valid && In_Ready) begin
          sw = (m_idx == 0) ? Swap : m_sw;
          if (m_idx == 0) m_sw = Swap;
          re = sw ? A32[15:0] : A32[31:16];
          im = sw ? A32[31:16] : A32[15:0];
          lst = m_idx == 63;
          q0.push_back({mscale(re, 6), mscale(im, 6), lst});
          q1.push_back({re, im, lst});
          m_idx = (m_idx + 1) % 64;
        end
        if (Out_Valid && Out_Ready) begin
          checks++;
          if (q0.size() == 0) begin
            errors++; $display("FAIL out_extra got %h/%b required none", R32, Out_Last);
          end else begin
            e = q0.pop_front();
            if ({R32, Out_Last} !== e) begin
              errors++; $display("FAIL out_word got %h/%b required %h/%b", R32, Out_Last, e[32:1], e[0]);
            end
          end
          if (Out_Last) lasts.push_back(out_cnt);
          out_cnt++;
        end
        if (Out_Valid_z && Out_Ready) begin
          checks++;
          if (q1.size() == 0) begin
            errors++; $display("FAIL outz_extra got %h/%b required none", R32_z, Out_Last_z);
          end else begin
            e = q1.pop_front();
            if ({R32_z, Out_Last_z} !== e) begin
              errors++; $display("FAIL outz_word got %h/%b required %h/%b", R32_z, Out_Last_z, e[32:1], e[0]);
            end
          end
        end
      end
    end
  end

  task automatic cyc(input logic [31:0] a, input logic sw, input logic v, input logic ordy, output logic acc);
    @(negedge CLK);
    A32 = a; Swap = sw; In_Valid = v; Out_Ready = ordy;
    #1 acc = v & In_Ready;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1; In_Valid = 0; Out_Ready = 0;
    repeat (2) @(negedge CLK);
    RST = 0;
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      cyc(32'h0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    cyc(32'h0, 1'b0, 1'b0, 1'b1, acc);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL drain_timeout got %0d/%0d pending required 0", q0.size(), q1.size());
    end
  endtask

  task automatic send(input logic [31:0] a, input logic sw, input bit rnd);
    logic acc = 0;
    int n = 0;
    while (!acc && n < 100) begin
      cyc(a, sw, rnd ? ($urandom % 4 != 0) : 1'b1, rnd ? ($urandom % 4 != 0) : 1'b1, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++; $display("FAIL send_timeout got no accept required accept");
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1; In_Valid = 1; Out_Ready = 1; A32 = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if ({Out_Valid, Out_Last, R32, In_Ready, Out_Valid_z} !== 35'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b l=%b r=%h rdy=%b vz=%b required all 0", Out_Valid, Out_Last, R32, In_Ready, Out_Valid_z);
    end
    RST = 0; In_Valid = 0;
  endtask

  task automatic test_swap_latency();
    logic acc;
    do_reset();
    cyc(32'h1234ABCD, 1'b1, 1'b1, 1'b1, acc);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL lat_accept got %b required 1", acc); end
    cyc(32'h0, 1'b0, 1'b0, 1'b1, acc);
    checks++;
    if (Out_Valid_z !== 1'b0) begin errors++; $display("FAIL lat_early got %b required 0", Out_Valid_z); end
    cyc(32'h0, 1'b0, 1'b0, 1'b1, acc);
    checks++;
    if (Out_Valid_z !== 1'b1 || R32_z !== 32'hABCD1234) begin
      errors++; $display("FAIL lat_swap got v=%b %h required v=1 abcd1234", Out_Valid_z, R32_z);
    end
    drain();
  endtask

  task automatic test_rounding();
    logic [31:0] w[3] = '{32'h0040FFC0, 32'h0020FFE0, 32'h001FFFDF};
    logic [31:0] x[3] = '{32'h0001FFFF, 32'h00010000, 32'h0000FFFF};
    logic acc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(i < 3 ? w[i] : 32'h0, 1'b0, i < 3, 1'b1, acc);
      if (i >= 2) begin
        checks++;
        if (Out_Valid !== 1'b1 || R32 !== x[i-2]) begin
          errors++; $display("FAIL round_%0d got v=%b %h required v=1 %h", i - 2, Out_Valid, R32, x[i-2]);
        end
      end
    end
    drain();
  endtask

  task automatic test_frames();
    do_reset();
    for (int j = 0; j < 128; j++)
      send($urandom, j < 64 ? (j < 10) : (j == 64 ? 1'b0 : 1'($urandom)), 1'b1);
    drain();
    checks++;
    if (out_cnt != 128 || lasts.size() != 2 || (lasts.size() == 2 && (lasts[0] != 63 || lasts[1] != 127))) begin
      errors++; $display("FAIL frame_last got cnt=%0d lasts=%p required cnt=128 lasts 63,127", out_cnt, lasts);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    logic acc;
    int k = 0;
    do_reset();
    repeat (6) begin cyc(32'h10000000 + k, 1'b0, 1'b1, 1'b1, acc); if (acc) k++; end
    for (int s = 0; s < 5; s++) begin
      cyc(32'h10000000 + k, 1'b0, 1'b1, 1'b0, acc);
      if (acc) k++;
      if (s == 0) held = R32;
      checks++;
      if (Out_Valid !== 1'b1 || In_Ready !== 1'b0 || R32 !== held) begin
        errors++; $display("FAIL stall_%0d got v=%b rdy=%b %h required v=1 rdy=0 %h", s, Out_Valid, In_Ready, R32, held);
      end
    end
    repeat (6) begin cyc(32'h10000000 + k, 1'b0, 1'b1, 1'b1, acc); if (acc) k++; end
    drain();
    checks++;
    if (out_cnt != k) begin errors++; $display("FAIL stall_count got %0d required %0d", out_cnt, k); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int j = 0; j < 31; j++) send($urandom, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1; In_Valid = 0;
    @(negedge CLK);
    RST = 0;
    #1;
    checks++;
    if (Out_Valid !== 1'b0 || Out_Valid_z !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got %b/%b required 0/0", Out_Valid, Out_Valid_z);
    end
    for (int j = 0; j < 64; j++) send($urandom, j == 0 ? 1'b1 : 1'($urandom), 1'b0);
    drain();
    checks++;
    if (out_cnt != 64 || lasts.size() != 1 || (lasts.size() == 1 && lasts[0] != 63)) begin
      errors++; $display("FAIL midrst_last got cnt=%0d lasts=%p required cnt=64 lasts 63", out_cnt, lasts);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_swap_latency();
    test_rounding();
    test_frames();
    test_stall();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
